bsg_down_read_ctrl: RTL and testbench
=====================================

Name: bsg_down_read_ctrl

Overview:
Read-side sequencer for the downstream link channel buffer (64 x 16-bit entries, written by the IO domain).
- Drains the buffer two half-words at a time and assembles each 32-bit core word.
- Presents the word to the core with a valid/ready handshake.
- Returns credits to the upstream sender as a decimated toggling token.
- Exports its read pointer so the write domain can synchronize it.

Parameters:
ADDR_W, 6, buffer address width; depth = 2**ADDR_W
HALF_W, 16, buffer entry width; core word = 2*HALF_W
TOKEN_DECIMATION, 4, core words accepted per io_token_out toggle; power of two, >=1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wptr_sync  in  ADDR_W+1  write pointer already synchronized into clk domain, MSB = wrap bit
buf_raddr  out  ADDR_W  buffer read address, combinational = rptr[ADDR_W-1:0]
buf_rdata  in  HALF_W  buffer read data, combinational from buf_raddr (same cycle)
core_data_out  out  2*HALF_W  assembled word {second half, first half}
core_valid_out  out  1  word valid
core_ready  in  1  core accepts word
io_token_out  out  1  credit token, toggles once per TOKEN_DECIMATION accepted words
rptr  out  ADDR_W+1  read pointer incl. wrap bit
empty  out  1  wptr_sync == rptr (all ADDR_W+1 bits)
occupancy  out  ADDR_W+2  (wptr_sync - rptr) mod 2**(ADDR_W+1), zero-extended
overflow_err  out  1  sticky; set when occupancy > 2**ADDR_W

Behaviour:
- Reset values: rptr=0, core_data_out=0, core_valid_out=0, io_token_out=0, overflow_err=0, lo_half=0, tok_cnt=0, state=S_LO.
- Reset asserted mid-word discards any latched lo_half and clears valid; no partial word survives.
- The FSM states are listed below.
  - S_LO (core_valid_out=0):
    - If !empty: lo_half<=buf_rdata, rptr<=rptr+1, go to S_HI.
    - Else stay.
  - S_HI:
    - If !empty: core_data_out<={buf_rdata, lo_half}, core_valid_out<=1, rptr<=rptr+1, go to S_OUT.
    - Else stay holding lo_half; a single buffered half never produces a word.
  - S_OUT:
    - core_data_out and core_valid_out are held stable while core_ready=0.
    - If core_ready: core_valid_out<=0, token update, go to S_LO.
    - No buffer read occurs in S_OUT.
- A half-word is consumed only in S_LO when rptr[0]=0, and only in S_HI when rptr[0]=1.
- rptr increments modulo 2**(ADDR_W+1); the wrap bit flips when crossing 2**ADDR_W-1 -> 0 in the address field.
- Timing:
  - Minimum 3 cycles per word (LO, HI, accept).
  - valid rises 2 cycles after the first half becomes available, assuming both halves are present.
- Token: on each accept, tok_cnt<=tok_cnt+1 mod TOKEN_DECIMATION. When tok_cnt==TOKEN_DECIMATION-1, io_token_out toggles in the same update.
- occupancy and empty are combinational from the current registers.
- overflow_err sets on the clock edge where occupancy > 2**ADDR_W and clears only on rst. Reads continue normally after it sets.
- wptr_sync may change in any state. Its effect is evaluated each cycle through empty.

Decomposition:
- Package bsg_down_pkg:
  - state enum {S_LO, S_HI, S_OUT}
  - default ADDR_W, HALF_W, TOKEN_DECIMATION constants
  - ptr_t typedef (ADDR_W+1 bits)
- Sub-module bsg_down_token_gen: decimating accept counter plus toggle register (inputs clk, rst, accept; output token).

Test Plan:
- Reset with wptr_sync=0 -> all outputs 0, empty=1, buf_raddr=0, no rptr movement over 10 cycles.
- Buffer[0]=0x1111, buffer[1]=0x2222, wptr_sync=2, core_ready=1 -> core_data_out=0x22221111 and valid=1 two cycles after stimulus, rptr=2, valid drops after one accept cycle.
- wptr_sync=1 only -> rptr=1, state S_HI, valid stays 0. Raise wptr_sync=2 five cycles later -> word appears the next cycle.
- Word valid with core_ready=0 for 8 cycles, wptr_sync=6 -> data/valid held, rptr stays 2. Ready pulse -> next word 0x44443333 follows.
- rptr preloaded via traffic to 62, wptr_sync=66 -> buf_raddr sequence 62, 63, 0, 1; rptr MSB flips to 1; empty at rptr=66.
- 8 words accepted with TOKEN_DECIMATION=4 -> io_token_out toggles after accept 4 and accept 8 (0->1->0). With rptr=0, drive wptr_sync=65 -> occupancy=65, overflow_err=1 and sticky until rst.

Source files
------------

// File: rtl/bsg_down_read_ctrl_pkg.sv
// bsg_down_pkg: shared types and default sizing for the downstream read sequencer.
package bsg_down_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_HALF_W = 16;
  localparam int DEF_TOKEN_DECIMATION = 4;
  typedef logic [DEF_ADDR_W:0] ptr_t;
  typedef enum logic [1:0] {S_LO, S_HI, S_OUT} state_e;
endpackage

// File: rtl/bsg_down_read_ctrl_if.sv
// bsg_down_read_ctrl_if: buffer read port plus core valid/ready word channel.
interface bsg_down_read_ctrl_if #(parameter int ADDR_W = 6, parameter int HALF_W = 16);
  logic [ADDR_W-1:0] buf_raddr;
  logic [HALF_W-1:0] buf_rdata;
  logic [2*HALF_W-1:0] core_data_out;
  logic core_valid_out;
  logic core_ready;
  modport master(output buf_raddr, core_data_out, core_valid_out, input buf_rdata, core_ready);
  modport slave(input buf_raddr, core_data_out, core_valid_out, output buf_rdata, core_ready);
endinterface

// File: rtl/bsg_down_read_ctrl_token_gen.sv
// bsg_down_token_gen: toggles token once every DEC accepted words.
module bsg_down_token_gen #(parameter int DEC = 4) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  output logic token
);
  localparam int CW = DEC > 1 ? $clog2(DEC) : 1;
  logic [CW-1:0] tok_cnt;
  logic last;
  assign last = tok_cnt == CW'(DEC - 1);
  always_ff @(posedge clk)
    if (rst) begin
      tok_cnt <= '0;
      token <= 1'b0;
    end else if (accept) begin
      tok_cnt <= last ? '0 : tok_cnt + CW'(1);
      if (last) token <= ~token;
    end
endmodule

// File: rtl/bsg_down_read_ctrl.sv
// bsg_down_read_ctrl: drains half-word buffer pairs into 32-bit core words and returns credits.
module bsg_down_read_ctrl
  import bsg_down_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int HALF_W = DEF_HALF_W,
  parameter int TOKEN_DECIMATION = DEF_TOKEN_DECIMATION
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W:0]       wptr_sync,
  bsg_down_read_ctrl_if.master  bus,
  output logic                  io_token_out,
  output logic [ADDR_W:0]       rptr,
  output logic                  empty,
  output logic [ADDR_W+1:0]     occupancy,
  output logic                  overflow_err
);
  localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(1) << ADDR_W;
  state_e state, state_n;
  logic [HALF_W-1:0] lo_half;
  logic [2*HALF_W-1:0] data_q;
  logic [ADDR_W:0] diff;
  logic ld_lo, ld_hi, accept;
  assign diff = wptr_sync - rptr;
  assign occupancy = {1'b0, diff};
  assign empty = wptr_sync == rptr;
  // pointer parity guards keep the two halves of a word aligned to even/odd entries
  assign ld_lo = state == S_LO && !empty && !rptr[0];
  assign ld_hi = state == S_HI && !empty && rptr[0];
  assign accept = state == S_OUT && bus.core_ready;
  assign bus.buf_raddr = rptr[ADDR_W-1:0];
  assign bus.core_data_out = data_q;
  assign bus.core_valid_out = state == S_OUT;
  always_ff @(posedge clk)
    if (rst) state <= S_LO;
    else state <= state_n;
  always_comb
    state_n = ld_lo ? S_HI : ld_hi ? S_OUT : accept ? S_LO : state;
  always_ff @(posedge clk)
    if (rst) begin
      rptr <= '0;
      lo_half <= '0;
      data_q <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (ld_lo || ld_hi) rptr <= rptr + (ADDR_W+1)'(1);
      if (ld_lo) lo_half <= bus.buf_rdata;
      if (ld_hi) data_q <= {bus.buf_rdata, lo_half};
      if (occupancy > DEPTH) overflow_err <= 1'b1;
    end
  bsg_down_token_gen #(.DEC(TOKEN_DECIMATION)) u_tok (
    .clk(clk),
    .rst(rst),
    .accept(accept),
    .token(io_token_out)
  );
endmodule

// File: tb/tb_bsg_down_read_ctrl.sv
// tb_bsg_down_read_ctrl: directed plus randomized traffic against a half-word stream scoreboard.
module tb_bsg_down_read_ctrl;
  localparam int AW = 6;
  localparam int HW = 16;
  localparam int DEC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW:0] wptr_sync = '0;
  logic io_token_out, empty, overflow_err;
  logic [AW:0] rptr;
  logic [AW+1:0] occupancy;
  logic [HW-1:0] mem [64];
  logic [HW-1:0] hist [$];
  int checks = 0, errors = 0;
  int wp = 0, acc = 0, rd_idx = 0;
  bit mon_on = 1'b1;
  bsg_down_read_ctrl_if #(.ADDR_W(AW), .HALF_W(HW)) bi ();
  assign bi.buf_rdata = mem[bi.buf_raddr];
  bsg_down_read_ctrl #(.ADDR_W(AW), .HALF_W(HW), .TOKEN_DECIMATION(DEC)) dut (
    .clk(clk), .rst(rst), .wptr_sync(wptr_sync), .bus(bi.master),
    .io_token_out(io_token_out), .rptr(rptr), .empty(empty),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_half(input logic [HW-1:0] v);
    mem[wp % 64] = v;
    hist.push_back(v);
    wp++;
    wptr_sync = (AW+1)'(wp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wptr_sync = '0;
    bi.core_ready = 1'b0;
    step(2);
    hist.delete();
    wp = 0;
    rst = 1'b0;
  endtask

  // scoreboard: every accepted word is the next two written half-words, low first
  always @(negedge clk)
    if (rst) begin
      acc = 0;
      rd_idx = 0;
    end else if (mon_on) begin
      check("token", io_token_out, 64'((acc / DEC) % 2));
      check("empty", empty, wptr_sync == rptr);
      check("occupancy", occupancy, 64'((int'(wptr_sync) - int'(rptr) + 128) % 128));
      check("rptr_lag", ((int'(rptr) - 2 * acc) % 128 + 128) % 128 <= 2, 1);
      if (bi.core_valid_out && bi.core_ready) begin
        if (hist.size() >= rd_idx + 2) check("word", bi.core_data_out, {hist[rd_idx+1], hist[rd_idx]});
        else check("word_underrun", hist.size(), rd_idx + 2);
        rd_idx += 2;
        acc++;
      end
    end

  task automatic rand_phase(input int target);
    int guard = 0;
    while (wp < target && guard < 20000) begin
      bi.core_ready = 1'($urandom_range(0, 1));
      if ((wp - 2 * acc) < 60 && $urandom_range(0, 2) != 0) write_half(HW'($urandom));
      step(1);
      guard++;
    end
    bi.core_ready = 1'b1;
    guard = 0;
    while (!(rptr == wptr_sync && !bi.core_valid_out) && guard < 2000) begin
      if ($urandom_range(0, 3) == 0) bi.core_ready = 1'b0;
      else bi.core_ready = 1'b1;
      step(1);
      guard++;
    end
    check("drain_timeout", guard < 2000, 1);
    check("drained_words", acc, wp / 2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bi.core_ready = 1'b0;
    do_reset();
    check("rst_valid", bi.core_valid_out, 0);
    check("rst_data", bi.core_data_out, 0);
    check("rst_token", io_token_out, 0);
    check("rst_rptr", rptr, 0);
    check("rst_empty", empty, 1);
    check("rst_raddr", bi.buf_raddr, 0);
    check("rst_ovf", overflow_err, 0);
    step(10);
    check("idle_rptr", rptr, 0);
    check("idle_valid", bi.core_valid_out, 0);

    bi.core_ready = 1'b1;
    write_half(16'h1111);
    write_half(16'h2222);
    step(1);
    check("w1_early_valid", bi.core_valid_out, 0);
    step(1);
    check("w1_valid", bi.core_valid_out, 1);
    check("w1_data", bi.core_data_out, 32'h22221111);
    check("w1_rptr", rptr, 2);
    step(1);
    check("w1_drop", bi.core_valid_out, 0);

    write_half(16'hAAAA);
    step(2);
    check("half_rptr", rptr, 3);
    check("half_valid", bi.core_valid_out, 0);
    step(5);
    check("half_hold_rptr", rptr, 3);
    check("half_hold_valid", bi.core_valid_out, 0);
    write_half(16'hBBBB);
    step(1);
    check("half_word_valid", bi.core_valid_out, 1);
    check("half_word_data", bi.core_data_out, 32'hBBBBAAAA);
    step(1);

    bi.core_ready = 1'b0;
    write_half(16'hC1C1);
    write_half(16'hC2C2);
    write_half(16'h3333);
    write_half(16'h4444);
    step(2);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("stall_valid", bi.core_valid_out, 1);
      check("stall_data", bi.core_data_out, 32'hC2C2C1C1);
      check("stall_rptr", rptr, 6);
    end
    bi.core_ready = 1'b1;
    step(1);
    bi.core_ready = 1'b0;
    check("pulse_drop", bi.core_valid_out, 0);
    step(2);
    check("next_valid", bi.core_valid_out, 1);
    check("next_data", bi.core_data_out, 32'h44443333);
    check("next_rptr", rptr, 8);
    bi.core_ready = 1'b1;
    step(1);
    check("token_after4", io_token_out, 1);

    rand_phase(62);
    check("pre_wrap_rptr", rptr, 62);
    for (int i = 0; i < 4; i++) write_half(HW'($urandom));
    check("wrap_raddr0", bi.buf_raddr, 62);
    step(1);
    check("wrap_raddr1", bi.buf_raddr, 63);
    step(1);
    check("wrap_raddr2", bi.buf_raddr, 0);
    check("wrap_msb", rptr[AW], 1);
    step(2);
    check("wrap_raddr3", bi.buf_raddr, 1);
    step(1);
    check("wrap_rptr", rptr, 66);
    check("wrap_empty", empty, 1);
    step(1);
    rand_phase(300);

    do_reset();
    bi.core_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_half(HW'($urandom));
    step(12);
    check("tok_4", io_token_out, 1);
    step(12);
    check("tok_8", io_token_out, 0);
    check("tok_acc", acc, 8);

    mon_on = 1'b0;
    do_reset();
    wptr_sync = 7'd65;
    #1;
    check("ovf_occ", occupancy, 65);
    check("ovf_pre", overflow_err, 0);
    step(1);
    check("ovf_set", overflow_err, 1);
    wptr_sync = '0;
    step(10);
    check("ovf_sticky", overflow_err, 1);
    rst = 1'b1;
    step(1);
    check("ovf_clear", overflow_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
